// File: rtl/hvac_sequencer.sv
// HVAC heat/cool sequencer: fan pre-purge, minimum run time, fan post-purge
// and anti-short-cycle lockout, with Moore-decoded actuator enables.
module hvac_sequencer #(
  parameter int unsigned PURGE   = 3,
  parameter int unsigned MIN_ON  = 8,
  parameter int unsigned MIN_OFF = 6,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       heat_req,
  input  logic       cool_req,
  output logic       heat_en,
  output logic       cool_en,
  output logic       fan_en,
  output logic [2:0] state,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HEAT = 3'd2,
    S_COOL = 3'd3,
    S_POST = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] PURGE_LAST   = CNT_W'(PURGE - 1);
  localparam logic [CNT_W-1:0] MIN_ON_LAST  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] MIN_OFF_LAST = CNT_W'(MIN_OFF - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX    = '1;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;   // 0 = heat, 1 = cool
  logic [CNT_W-1:0] timer_q;
  logic             req_sel;
  logic             both_req;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and mode selection
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    req_sel  = mode_q ? cool_req : heat_req;
    both_req = heat_req & cool_req;
    case (state_q)
      S_IDLE: begin
        if (heat_req ^ cool_req) begin
          state_d = S_PRE;
          mode_d  = cool_req;
        end
      end
      S_PRE: begin
        if (!req_sel) begin
          state_d = S_POST;
        end else if (timer_q == PURGE_LAST) begin
          state_d = mode_q ? S_COOL : S_HEAT;
        end
      end
      S_HEAT, S_COOL: begin
        if ((timer_q >= MIN_ON_LAST) && (!req_sel || both_req)) begin
          state_d = S_POST;
        end
      end
      S_POST: begin
        if (timer_q == PURGE_LAST) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (timer_q == MIN_OFF_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Phase timer: clears on any transition, otherwise counts up and saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (state_d != state_q) begin
      timer_q <= '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_q <= timer_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Enables are registered decodes of the next state, so they track state_q exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heat_en <= 1'b0;
      cool_en <= 1'b0;
      fan_en  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      heat_en <= (state_d == S_HEAT);
      cool_en <= (state_d == S_COOL);
      fan_en  <= (state_d == S_PRE) || (state_d == S_POST) ||
                 (state_d == S_HEAT) || (state_d == S_COOL);
      fault   <= heat_req & cool_req;
    end
  end

  assign state = state_q;

endmodule
